// File: rtl/pll_lock_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock and releases sys_rst_n.
// Optional lock-loss counter and pulse are built when PLL_LOCK_SEQ_LOSS_CNT_EN is defined.
module pll_lock_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       pll_ready,
    output logic       lock_fail,
    output logic [3:0] retry_cnt,
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    output logic [7:0] lock_loss_cnt,
    output logic       lock_lost_pulse,
`endif
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [31:0]      MAX_RETRY_U  = 32'(MAX_RETRIES);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_retry_cnt;
    logic               r_sync_meta;
    logic               r_locked_s;
    logic               r_pll_rst;
    logic               r_sys_rst_n;
    logic               r_pll_ready;
    logic               r_lock_fail;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [3:0]         w_retry_nxt;
    logic [3:0]         w_retry_inc;
    logic               w_retry_exhausted;
    logic               w_pll_rst_nxt;
    logic               w_sys_rst_n_nxt;
    logic               w_pll_ready_nxt;
    logic               w_lock_fail_nxt;

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    logic [7:0]         r_loss_cnt;
    logic               r_lost_pulse;
    logic               w_lost_nxt;
`endif

    assign w_retry_inc       = (r_retry_cnt == 4'hF) ? 4'hF : (r_retry_cnt + 4'd1);
    assign w_retry_exhausted = ({28'd0, w_retry_inc} == MAX_RETRY_U);

    // State register plus the registered outputs decoded from next-state.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_retry_cnt <= 4'd0;
            r_sync_meta <= 1'b0;
            r_locked_s  <= 1'b0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_pll_ready <= 1'b0;
            r_lock_fail <= 1'b0;
        end else begin
            r_sync_meta <= pll_locked;
            r_locked_s  <= r_sync_meta;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_pll_rst   <= w_pll_rst_nxt;
            r_sys_rst_n <= w_sys_rst_n_nxt;
            r_pll_ready <= w_pll_ready_nxt;
            r_lock_fail <= w_lock_fail_nxt;
        end
    end

    // Lock seen in WAIT_LOCK wins over a timeout landing on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry_cnt;
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_retry_nxt = w_retry_inc;
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_retry_exhausted ? S_FAIL : S_PLL_RST;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_STABLE: begin
                if (!r_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_RUN: begin
                if (!r_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            S_FAIL: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = S_PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_pll_rst_nxt   = (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_FAIL);
        w_sys_rst_n_nxt = (w_state_nxt == S_RUN);
        w_pll_ready_nxt = (w_state_nxt == S_RUN);
        w_lock_fail_nxt = (w_state_nxt == S_FAIL);
    end

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    assign w_lost_nxt = (r_state == S_RUN) && (w_state_nxt == S_WAIT_LOCK);

    always_ff @(posedge refclk) begin
        if (!rst) begin
            r_loss_cnt   <= 8'd0;
            r_lost_pulse <= 1'b0;
        end else begin
            r_lost_pulse <= w_lost_nxt;
            if (w_lost_nxt && (r_loss_cnt != 8'hFF)) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end
        end
    end

    assign lock_loss_cnt   = r_loss_cnt;
    assign lock_lost_pulse = r_lost_pulse;
`endif

    assign pll_rst   = r_pll_rst;
    assign sys_rst_n = r_sys_rst_n;
    assign pll_ready = r_pll_ready;
    assign lock_fail = r_lock_fail;
    assign retry_cnt = r_retry_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Bench for pll_lock_seq: phase/age reference model feeding an expected queue,
// per-cycle compare on the falling edge, and directed latency checks.
`timescale 1ns/1ps
module tb_pll_lock_seq;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int CNT_W         = 17;
    localparam int W             = 17;

    localparam int PH_PULSE  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_UP     = 3;
    localparam int PH_DEAD   = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       pll_ready;
    logic       lock_fail;
    logic [3:0] retry_cnt;
    logic [2:0] dbg_state;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
    logic       lock_lost_pulse;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    // model state
    logic [1:0] m_lk = 2'b00;
    int m_phase = PH_PULSE;
    int m_age = 0;
    int m_retries = 0;
    int m_losses = 0;
    logic m_pulse = 1'b0;

    pll_lock_seq #(
        .RST_CYCLES(RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES(MAX_RETRIES),
        .CNT_W(CNT_W)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .pll_rst(pll_rst),
        .sys_rst_n(sys_rst_n),
        .pll_ready(pll_ready),
        .lock_fail(lock_fail),
        .retry_cnt(retry_cnt),
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        .lock_loss_cnt(lock_loss_cnt),
        .lock_lost_pulse(lock_lost_pulse),
`endif
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #10 refclk = ~refclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // reference model
    task automatic enter(input int p);
        m_phase = p;
        m_age   = 0;
    endtask

    task automatic model_step(input logic r_n, input logic lk);
        logic seen;
        if (!r_n) begin
            m_lk = 2'b00; m_phase = PH_PULSE; m_age = 0;
            m_retries = 0; m_losses = 0; m_pulse = 1'b0;
            return;
        end
        seen = m_lk[1];
        m_lk = {m_lk[0], lk};
        m_pulse = 1'b0;
        m_age++;
        case (m_phase)
            PH_PULSE: if (m_age == RST_CYCLES) enter(PH_WAIT);
            PH_WAIT: begin
                if (seen) enter(PH_SETTLE);
                else if (m_age == LOCK_TIMEOUT) begin
                    m_retries = (m_retries < 15) ? m_retries + 1 : 15;
                    enter((m_retries == MAX_RETRIES) ? PH_DEAD : PH_PULSE);
                end
            end
            PH_SETTLE: begin
                if (!seen) enter(PH_WAIT);
                else if (m_age == STABLE_CYCLES) begin
                    enter(PH_UP);
                    m_retries = 0;
                end
            end
            PH_UP: begin
                if (!seen) begin
                    enter(PH_WAIT);
                    m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                    m_pulse  = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [W-1:0] model_vec();
        logic [W-1:0] v;
        v = '0;
        v[3:0] = 4'(m_retries);
        v[4]   = (m_phase == PH_DEAD);
        v[5]   = (m_phase == PH_UP);
        v[6]   = (m_phase == PH_UP);
        v[7]   = (m_phase == PH_PULSE) || (m_phase == PH_DEAD);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        v[8]    = m_pulse;
        v[16:9] = 8'(m_losses);
`endif
        return v;
    endfunction

    function automatic logic [W-1:0] dut_vec();
        logic [W-1:0] v;
        v = '0;
        v[3:0] = retry_cnt;
        v[4]   = lock_fail;
        v[5]   = pll_ready;
        v[6]   = sys_rst_n;
        v[7]   = pll_rst;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        v[8]    = lock_lost_pulse;
        v[16:9] = lock_loss_cnt;
`endif
        return v;
    endfunction

    always @(posedge refclk) begin
        model_step(rst, pll_locked);
        exp_q.push_back(model_vec());
    end

    // scoreboard compare, once per cycle away from the active edge
    always @(negedge refclk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_vec();
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, a, e);
            end
        end
    end

    // driver tasks
    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    // which: 0 sys_rst_n high, 1 sys_rst_n low, 2 retry_cnt==1, 3 lock_fail high
    task automatic wait_edges(input int which, input int limit, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            tick(1);
            n++;
            case (which)
                0: hit = (sys_rst_n === 1'b1);
                1: hit = (sys_rst_n === 1'b0);
                2: hit = (retry_cnt === 4'd1);
                3: hit = (lock_fail === 1'b1);
                default: hit = 1'b1;
            endcase
        end
        if (!hit) n = -1;
    endtask

    initial begin
        int n;
        int hold;
        tick(3);
        check("reset_pll_rst", int'(pll_rst), 1);
        check("reset_sys_rst_n", int'(sys_rst_n), 0);
        check("reset_pll_ready", int'(pll_ready), 0);
        check("reset_lock_fail", int'(lock_fail), 0);
        check("reset_retry_cnt", int'(retry_cnt), 0);

        // normal bring-up
        rst = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 50) begin
            n++;
            tick(1);
        end
        check("pll_rst_pulse_cycles", n, 4);
        tick(6);
        pll_locked = 1'b1;
        wait_edges(0, 100, n);
        check("release_latency", n, 11);
        check("run_pll_ready", int'(pll_ready), 1);
        check("run_retry_cnt", int'(retry_cnt), 0);

        // lock loss in RUN, then recovery
        tick(5);
        pll_locked = 1'b0;
        wait_edges(1, 20, n);
        check("drop_latency", n, 3);
        check("drop_pll_ready", int'(pll_ready), 0);
        check("drop_pll_rst", int'(pll_rst), 0);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        check("loss_cnt", int'(lock_loss_cnt), 1);
        check("lost_pulse_on", int'(lock_lost_pulse), 1);
`endif
        pll_locked = 1'b1;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        tick(1);
        check("lost_pulse_off", int'(lock_lost_pulse), 0);
        wait_edges(0, 100, n);
        check("rerelease_latency", n + 1, 11);
`else
        wait_edges(0, 100, n);
        check("rerelease_latency", n, 11);
`endif

        // rst while in RUN
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_run_pll_rst", int'(pll_rst), 1);
        check("rst_run_sys_rst_n", int'(sys_rst_n), 0);
        check("rst_run_retry_cnt", int'(retry_cnt), 0);
        rst = 1'b1;
        wait_edges(0, 100, n);
        check("rst_run_resequence", n, 13);

        // single-cycle glitch during the stability window
        pll_locked = 1'b0;
        wait_edges(1, 20, n);
        pll_locked = 1'b1;
        tick(8);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        wait_edges(0, 100, n);
        check("glitch_restart_latency", n, 11);
        check("glitch_retry_cnt", int'(retry_cnt), 0);

        // lock never arrives -> retry then FAIL
        pll_locked = 1'b0;
        do_reset();
        wait_edges(2, 200, n);
        check("first_timeout_edge", n, 24);
        check("retry_pll_rst", int'(pll_rst), 1);
        wait_edges(3, 200, n);
        check("fail_edge", n, 24);
        check("fail_retry_cnt", int'(retry_cnt), 2);
        repeat (30) begin
            pll_locked = 1'($urandom_range(0, 1));
            tick(1);
        end
        check("fail_sticky", int'(lock_fail), 1);
        check("fail_pll_rst", int'(pll_rst), 1);
        pll_locked = 1'b0;
        do_reset();
        check("fail_cleared", int'(lock_fail), 0);

        // one timeout, then lock
        wait_edges(2, 200, n);
        pll_locked = 1'b1;
        tick(6);
        check("stable_retry_kept", int'(retry_cnt), 1);
        wait_edges(0, 100, n);
        check("run_entry_retry_clr", int'(retry_cnt), 0);

        // randomized traffic, checked by the model each cycle
        repeat (300) begin
            hold = $urandom_range(1, 40);
            pll_locked = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b0;
                tick($urandom_range(1, 2));
                rst = 1'b1;
            end
            tick(hold);
        end

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
